// File: rtl/bcd_updown_scan_pkg.sv
// Shared constants for the BCD up/down counter with scanned seven-segment display.
// The segment glyphs are active-low and ordered {a,b,c,d,e,f,g}.
package bcd_updown_scan_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_updown_scan_digit.sv
// One BCD digit of the up/down counter: load with clamping to 9, count on enable,
// and a carry/borrow flag telling the next digit to step.
module bcd_digit
  import bcd_updown_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = (ld_val > 4'd9) ? 4'd9 : ld_val;
    end else if (en) begin
      if (up) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q         = q_q;
  assign carry_out = en & (up ? (q_q == 4'd9) : (q_q == 4'd0));

endmodule

// File: rtl/bcd_updown_scan.sv
// Multi-digit BCD up/down counter driven by a clock-enable tick, with a
// time-multiplexed, optionally leading-zero-blanked seven-segment driver.
module bcd_updown_scan
  import bcd_updown_scan_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int TICK_DIV      = 50000000,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    up_down,
  input  logic                    pause,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count_bcd,
  output logic                    tc,
  output logic                    tick,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TICK_W-1:0] tick_div_q, tick_div_d;
  logic [SCAN_W-1:0] scan_div_q, scan_div_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic              tc_q, tc_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [BCD_W-1:0]  digit_q [DIGITS];
  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] blank;
  logic              zero_run;
  logic              count_en;
  logic              scan_wrap;

  assign tick     = (tick_div_q == TICK_W'(TICK_DIV - 1));
  assign count_en = tick & ~pause & ~load;

  // Each digit steps only when every lower digit rolls over in the same tick.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign en[i] = count_en;
    end else begin : g_upper
      assign en[i] = carry[i-1];
    end

    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .en        (en[i]),
      .up        (up_down),
      .ld        (load),
      .ld_val    (load_val[i*BCD_W +: BCD_W]),
      .q         (digit_q[i]),
      .carry_out (carry[i])
    );

    assign count_bcd[i*BCD_W +: BCD_W] = digit_q[i];
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (digit_q[i] == 4'd0);
      blank[i] = (BLANK_LEADING != 0) & zero_run;
    end
  end

  // an and seg both come from the current index, so they always change together.
  always_comb begin
    tick_div_d = tick ? '0 : tick_div_q + TICK_W'(1);
    tc_d       = &carry;
    scan_wrap  = (scan_div_q == SCAN_W'(SCAN_DIV - 1));
    scan_div_d = scan_wrap ? '0 : scan_div_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_wrap) begin
      scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
    an_d  = ~(DIGITS'(1) << scan_idx_q);
    seg_d = blank[scan_idx_q] ? SEG_BLANK : seg_decode(digit_q[scan_idx_q]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_div_q <= '0;
      scan_div_q <= '0;
      scan_idx_q <= '0;
      tc_q       <= 1'b0;
      an_q       <= ~DIGITS'(1);
      seg_q      <= SEG_0;
    end else begin
      tick_div_q <= tick_div_d;
      scan_div_q <= scan_div_d;
      scan_idx_q <= scan_idx_d;
      tc_q       <= tc_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign tc  = tc_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_updown_scan.sv
// Directed self-checking bench for bcd_updown_scan with a 2-digit, fast-divider build.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_updown_scan;

  localparam int DIGITS        = 2;
  localparam int TICK_DIV      = 4;
  localparam int SCAN_DIV      = 3;
  localparam int BLANK_LEADING = 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       up_down  = 1'b1;
  logic       pause    = 1'b0;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count_bcd;
  logic       tc;
  logic       tick;
  logic [6:0] seg;
  logic [1:0] an;

  int assertCount = 0;
  int failCount   = 0;

  bcd_updown_scan #(
    .DIGITS        (DIGITS),
    .TICK_DIV      (TICK_DIV),
    .SCAN_DIV      (SCAN_DIV),
    .BLANK_LEADING (BLANK_LEADING)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up_down   (up_down),
    .pause     (pause),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .tc        (tc),
    .tick      (tick),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ud, input logic ps, input logic ld, input logic [7:0] lv);
    up_down  = ud;
    pause    = ps;
    load     = ld;
    load_val = lv;
  endtask

  task automatic waitTick(input string tag, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s: observed no tick expected tick within 16 cycles", tag);
    end
  endtask

  task automatic doLoad(input logic ud, input logic ps, input logic [7:0] lv);
    applyStimulus(ud, ps, 1'b1, lv);
    @(negedge clk);
    applyStimulus(ud, ps, 1'b0, lv);
  endtask

  task automatic syncAfterTick(input string tag);
    int c;
    waitTick(tag, c);
    @(negedge clk);
  endtask

  initial begin
    int         cyc;
    logic [7:0] expCount;
    logic [1:0] anS  [12];
    logic [6:0] segS [12];
    int         j;
    logic       seen01, seen10;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_count", count_bcd, 8'h00);
    checkOutput("rst_tick",  tick, 1'b0);
    checkOutput("rst_tc",    tc, 1'b0);
    checkOutput("rst_an",    an, 2'b10);
    checkOutput("rst_seg",   seg, 7'b0000001);
    reset = 1'b0;

    $display("[TB] count up 00..10");
    for (int k = 1; k <= 10; k++) begin
      waitTick("t1_wait", cyc);
      checkOutput("t1_period", cyc, 3);
      checkOutput("t1_hold", count_bcd, 8'(((k - 1) / 10) * 16 + ((k - 1) % 10)));
      @(negedge clk);
      expCount = 8'((k / 10) * 16 + (k % 10));
      checkOutput("t1_count", count_bcd, expCount);
      checkOutput("t1_tc", tc, 1'b0);
    end

    $display("[TB] up wrap from 98");
    syncAfterTick("t2_sync");
    doLoad(1'b1, 1'b0, 8'h98);
    checkOutput("t2_load", count_bcd, 8'h98);
    checkOutput("t2_load_tc", tc, 1'b0);
    waitTick("t2_wait1", cyc);
    @(negedge clk);
    checkOutput("t2_99", count_bcd, 8'h99);
    checkOutput("t2_99_tc", tc, 1'b0);
    waitTick("t2_wait2", cyc);
    checkOutput("t2_pre_tc", tc, 1'b0);
    @(negedge clk);
    checkOutput("t2_00", count_bcd, 8'h00);
    checkOutput("t2_wrap_tc", tc, 1'b1);
    @(negedge clk);
    checkOutput("t2_tc_drop", tc, 1'b0);
    checkOutput("t2_00_hold", count_bcd, 8'h00);

    $display("[TB] down wrap from 00");
    syncAfterTick("t3_sync");
    doLoad(1'b0, 1'b0, 8'h00);
    checkOutput("t3_load", count_bcd, 8'h00);
    waitTick("t3_wait1", cyc);
    @(negedge clk);
    checkOutput("t3_99", count_bcd, 8'h99);
    checkOutput("t3_wrap_tc", tc, 1'b1);
    waitTick("t3_wait2", cyc);
    checkOutput("t3_mid_tc", tc, 1'b0);
    @(negedge clk);
    checkOutput("t3_98", count_bcd, 8'h98);
    checkOutput("t3_98_tc", tc, 1'b0);

    $display("[TB] pause and clamped load");
    syncAfterTick("t4_sync");
    doLoad(1'b0, 1'b1, 8'h42);
    for (int k = 0; k < 3; k++) begin
      waitTick("t4_tick", cyc);
      @(negedge clk);
      checkOutput("t4_hold", count_bcd, 8'h42);
      checkOutput("t4_tc", tc, 1'b0);
    end
    doLoad(1'b0, 1'b1, 8'hF3);
    checkOutput("t4_clamp", count_bcd, 8'h93);
    checkOutput("t4_clamp_tc", tc, 1'b0);

    $display("[TB] scan with blanking at 07");
    doLoad(1'b1, 1'b1, 8'h07);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      anS[k]  = an;
      segS[k] = seg;
      checkOutput("t5_an_valid", (an == 2'b10) || (an == 2'b01), 1'b1);
      checkOutput("t5_seg_07", seg, (an == 2'b01) ? 7'b1111111 : 7'b0001111);
      @(negedge clk);
    end
    j = 0;
    for (int k = 1; k <= 3; k++) begin
      if (j == 0 && anS[k] != anS[k-1]) j = k;
    end
    checkOutput("t5_phase_found", j != 0, 1'b1);
    if (j != 0) begin
      for (int k = j; k <= j + 8; k++) begin
        checkOutput("t5_slot_len", anS[k], (((k - j) / 3) % 2 == 0) ? anS[j] : anS[j-1]);
      end
      checkOutput("t5_alternate", anS[j] ^ anS[j-1], 2'b11);
    end

    $display("[TB] scan at 17");
    doLoad(1'b1, 1'b1, 8'h17);
    @(negedge clk);
    seen01 = 1'b0;
    seen10 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (an == 2'b01) seen01 = 1'b1;
      if (an == 2'b10) seen10 = 1'b1;
      checkOutput("t5_seg_17", seg, (an == 2'b01) ? 7'b1001111 : 7'b0001111);
      @(negedge clk);
    end
    checkOutput("t5_both_slots", {seen01, seen10}, 2'b11);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    syncAfterTick("t6_sync");
    doLoad(1'b1, 1'b0, 8'h55);
    checkOutput("t6_load", count_bcd, 8'h55);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_count", count_bcd, 8'h00);
    checkOutput("t6_an",    an, 2'b10);
    checkOutput("t6_seg",   seg, 7'b0000001);
    checkOutput("t6_tc",    tc, 1'b0);
    checkOutput("t6_tick",  tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    waitTick("t6_wait", cyc);
    checkOutput("t6_first_tick", cyc, 3);
    checkOutput("t6_pre_count", count_bcd, 8'h00);
    @(negedge clk);
    checkOutput("t6_count_01", count_bcd, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bcd_updown_scan.md
Name: bcd_updown_scan

Overview:
Parametrised multi-digit BCD up/down counter with a time-multiplexed seven-segment display driver. It is the successor to the single-digit up/down counter.
- Uses a clock-enable tick instead of a derived clock.
- Adds DIGITS-wide BCD counting, synchronous load, a terminal-count pulse, optional leading-zero blanking and anode scanning.
- Sits between the board switches/buttons and the segment/anode pins.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count modulus is 10^DIGITS.
TICK_DIV, 50000000, clk cycles per count tick (>=2).
SCAN_DIV, 50000, clk cycles per display digit slot (>=2).
BLANK_LEADING, 1, 1 = blank leading zero digits above digit 0; 0 = show all digits.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  asynchronous, active-high; all state cleared immediately.
up_down  in  1  1 = count up, 0 = count down; sampled on tick cycles.
pause  in  1  1 = hold count; tick divider keeps running.
load  in  1  synchronous load strobe.
load_val  in  4*DIGITS  BCD load value; nibble 0 = least significant digit.
count_bcd  out  4*DIGITS  current count in BCD, registered.
tc  out  1  one-cycle terminal-count pulse, registered.
tick  out  1  one-cycle count-enable pulse, for debug and bench sync.
seg  out  7  segments {a,b,c,d,e,f,g}, active-low, registered.
an  out  DIGITS  digit enables, one-hot active-low, registered.

Behaviour:
Reset values:
- count_bcd = 0, tc = 0, tick = 0, both dividers = 0, scan index = 0.
- an = ~1 (digit 0 enabled); seg = 7'b0000001 (glyph "0").

Tick divider:
- Counts 0..TICK_DIV-1 and wraps.
- tick = 1 for exactly one cycle when the divider equals TICK_DIV-1, i.e. once every TICK_DIV cycles.
- First tick occurs TICK_DIV cycles after reset release.

Count priority, evaluated on each clk edge:
- load > (tick & ~pause) > hold.
- load = 1: count_bcd <= load_val on the next edge, regardless of tick or pause.
- Load clamping: any load nibble > 9 loads as 9. tc is not asserted by a load.

Count up (tick & ~pause & up_down):
- Digit 0 increments.
- A digit at 9 becomes 0 and carries into the next digit.
- All digits at 9 wrap to all-zero, and tc = 1 in the same cycle count_bcd shows zero.

Count down (tick & ~pause & ~up_down):
- Digit 0 decrements.
- A digit at 0 becomes 9 and borrows from the next digit.
- All-zero wraps to all-nines, and tc = 1 in the same cycle count_bcd shows all-nines.

Pause and tc:
- pause = 1 on a tick cycle: no change, tc = 0, tick still pulses.
- tc is deasserted on every cycle other than a wrap update.

Scan:
- The scan divider counts 0..SCAN_DIV-1.
- On wrap, the scan index advances 0 → 1 → … → DIGITS-1 → 0.
- an and seg update together, one cycle after the index changes, driven from the count_bcd value of that cycle. No ghosting, because both come from the same register stage.

Segment encoding (active-low, {a..g}):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Blank = 1111111.

Blanking (BLANK_LEADING = 1):
- Digit i > 0 is blanked iff digits i..DIGITS-1 are all zero.
- Digit 0 is never blanked. an still enables the slot.

Reset mid-operation: all outputs return to their reset values asynchronously. A pending tick or load is discarded.

Decomposition:
Shared package:
- Constant BCD_W = 4.
- Segment glyph constants SEG_0..SEG_9 and SEG_BLANK.
- Function seg_decode(bcd) returning 7 bits, with SEG_BLANK for codes > 9.

Sub-module bcd_digit (instantiated DIGITS times in a generate loop):
- Ports: clk, reset, en, up, ld, ld_val[3:0], q[3:0], carry_out.
- carry_out = en & (up ? q==9 : q==0).
- Ripple: digit i en = tick & ~pause & carry_out of digit i-1.
- tc = registered AND of all carry_outs at the counting tick.

Test Plan:
Bench parameters: DIGITS=2, TICK_DIV=4, SCAN_DIV=3, BLANK_LEADING=1.
1. Reset release, up_down=1 → tick every 4 cycles; count_bcd 0x00, 0x01 … 0x09, 0x10; digit 1 increments exactly on the 0x09→0x10 tick.
2. load with load_val=0x98, up_down=1 → next ticks give 0x99 then 0x00 with tc=1 for one cycle on the wrap; tc=0 on all other cycles.
3. load 0x00, up_down=0 → next tick gives 0x99 with tc=1; following tick gives 0x98 with tc=0.
4. pause=1 across 3 ticks at 0x42 → count_bcd stays 0x42, tick still pulses, tc=0; load of 0xF3 while paused → count_bcd=0x93 (clamped), no tc.
5. Count 0x07, observe scan → an alternates 2'b10/2'b01 every 3 cycles; digit 0 slot seg=0001111, digit 1 slot seg=1111111 (blanked); at 0x17 digit 1 slot seg=1001111.
6. Assert reset mid-count at 0x55 between clk edges → count_bcd=0x00, an=2'b10, seg=0000001, tc=0 immediately (asynchronous); first tick 4 cycles after release.
